// File: rtl/kb_pkg.sv
// Shared sizing constants and operation encoding for the keyboard receive buffer.
package kb_pkg;

  localparam int KB_DEPTH  = 16;
  localparam int KB_CHAR_W = 7;
  localparam int KB_PTR_W  = $clog2(KB_DEPTH);

  typedef enum logic [1:0] {
    KB_OP_NONE = 2'b00,
    KB_OP_POP  = 2'b01,
    KB_OP_PUSH = 2'b10,
    KB_OP_BOTH = 2'b11
  } kb_op_e;

endpackage

// File: rtl/kb_fifo_mem.sv
// Character storage: register array with a synchronous write port and an asynchronous read port.
module kb_fifo_mem
  import kb_pkg::*;
#(
  parameter int DEPTH  = KB_DEPTH,
  parameter int DATA_W = KB_CHAR_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/keyboard_buf.sv
// Receive-side character FIFO between the keyboard receiver and the CPU polling port.
// First-word-fall-through: read_data always shows the head entry, or zero when empty.
module keyboard_buf
  import kb_pkg::*;
#(
  parameter int DEPTH  = KB_DEPTH,
  parameter int DATA_W = KB_CHAR_W
) (
  input  logic              clk,
  input  logic              KB_clear,
  input  logic              write,
  input  logic [7:0]        write_data,
  input  logic              KB_read_en,
  output logic              KB_status,
  output logic [DATA_W-1:0] read_data,
  output logic              buf_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rdata;
  logic [7-DATA_W:0] w_unused_hi;
  kb_op_e            w_op;

  // The parity bit above the stored character is intentionally dropped.
  assign w_unused_hi = write_data[7:DATA_W];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A push while full is allowed only when a pop frees the head slot in the same edge.
  assign w_pop  = KB_read_en & ~w_empty;
  assign w_push = write & (~w_full | w_pop);

  always_comb begin
    w_op = KB_OP_NONE;
    case ({w_push, w_pop})
      2'b10:   w_op = KB_OP_PUSH;
      2'b01:   w_op = KB_OP_POP;
      2'b11:   w_op = KB_OP_BOTH;
      default: w_op = KB_OP_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (KB_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case (w_op)
        KB_OP_PUSH: r_count <= r_count + (PTR_W + 1)'(1);
        KB_OP_POP:  r_count <= r_count - (PTR_W + 1)'(1);
        default:    r_count <= r_count;
      endcase
    end
  end

  kb_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~KB_clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (write_data[DATA_W-1:0]),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign KB_status = ~w_empty;
  assign buf_full  = w_full;
  assign read_data = w_empty ? '0 : w_rdata;

endmodule

// File: tb/tb_keyboard_buf.sv
// Bench for keyboard_buf: queue-based reference model, scoreboard of popped characters, directed and random traffic.
module tb_keyboard_buf;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       KB_clear = 1'b0;
  logic       write = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       KB_read_en = 1'b0;
  logic       KB_status;
  logic [6:0] read_data;
  logic       buf_full;

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0] model_q[$];
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  keyboard_buf #(.DEPTH(DEPTH), .DATA_W(7)) dut (
    .clk        (clk),
    .KB_clear   (KB_clear),
    .write      (write),
    .write_data (write_data),
    .KB_read_en (KB_read_en),
    .KB_status  (KB_status),
    .read_data  (read_data),
    .buf_full   (buf_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus; the model applies the FIFO rules with plain queue operations.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic [6:0] head;
    write      = wr;
    write_data = d;
    KB_read_en = rd;
    KB_clear   = clr;
    if (clr) begin
      model_q.delete();
    end else begin
      if (rd && model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      if (wr && model_q.size() < DEPTH) model_q.push_back(d[6:0]);
    end
    @(posedge clk);
    #1;
    write      = 1'b0;
    KB_read_en = 1'b0;
    KB_clear   = 1'b0;
    head = (model_q.size() != 0) ? model_q[0] : 7'h00;
    check("KB_status", 32'(KB_status), 32'(model_q.size() != 0));
    check("buf_full",  32'(buf_full),  32'(model_q.size() == DEPTH));
    check("read_data", 32'(read_data), 32'(head));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: whenever the DUT presents a character that is being popped, compare against the scoreboard.
  always @(negedge clk) begin
    if (KB_read_en && !KB_clear && KB_status) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h expected no pop at %0t", read_data, $time);
      end else begin
        check("pop_data", 32'(read_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] hello [11];
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};

    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    foreach (hello[i]) begin
      step(1'b1, hello[i], 1'b0, 1'b0);
      idle(3);
    end
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(1);
    end

    step(1'b1, 8'h65, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    step(1'b1, 8'h51, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 8'hE8, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 8'h31, 1'b1, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b1, 1'b0);
    step(1'b1, 8'h35, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h7A, 1'b1, 1'b0);
    step(1'b1, 8'h7B, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 800; i++) begin
      logic wr, rd, clr;
      if (((i / 100) % 2) == 0) begin
        wr = ($urandom_range(99) < 70);
        rd = ($urandom_range(99) < 30);
      end else begin
        wr = ($urandom_range(99) < 30);
        rd = ($urandom_range(99) < 70);
      end
      clr = ($urandom_range(199) < 3);
      step(wr, 8'($urandom), rd, clr);
    end

    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
